// File: rtl/dbg_bridge_pkg.sv
// Shared types and constants for the UART-to-debug-port host bridge.
//  state_e     : bridge FSM states
//  STAT_*      : response status byte values
//  REQ_BYTES / RSP_BYTES : request / response frame lengths in bytes
//  rsp_byte()  : selects one byte of the response frame (status, then rdata LSB first)
package dbg_bridge_pkg;

    typedef enum logic [2:0] {
        RX_CMD,
        RX_ADDR,
        RX_DATA,
        ISSUE,
        WAIT_RDY,
        RELEASE,
        TX_RESP
    } state_e;

    localparam logic [7:0] STAT_OK     = 8'h00;
    localparam logic [7:0] STAT_INVAL  = 8'h01;
    localparam logic [7:0] STAT_TO_RDY = 8'hEE;
    localparam logic [7:0] STAT_TO_REL = 8'hED;

    localparam int unsigned REQ_BYTES  = 9;
    localparam int unsigned RSP_BYTES  = 5;
    // Request is cmd + equal-sized addr and data fields.
    localparam int unsigned FIELD_BYTES = (REQ_BYTES - 1) / 2;
    localparam int unsigned IDX_W       = 3;

    // Response frame byte mux: 0 = status, 1..4 = rdata LSB first.
    function automatic logic [7:0] rsp_byte(input logic [7:0]       status,
                                            input logic [31:0]      rdata,
                                            input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0:    return status;
            3'd1:    return rdata[7:0];
            3'd2:    return rdata[15:8];
            3'd3:    return rdata[23:16];
            3'd4:    return rdata[31:24];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/dbg_host_bridge.sv
// Host-side debug command port driver fed by a UART byte stream.
// Collects a 9-byte request (cmd, addr LSB first, data LSB first), issues one
// debug command, waits for ready and its release, then returns a 5-byte
// response (status, rdata LSB first).
// Ports:
//  clk, rst_i              : clock, synchronous active-high reset
//  rx_data_i, rx_valid_i   : received byte strobe (no backpressure)
//  tx_data_o, tx_valid_o, tx_ready_i : response byte stream, valid/ready
//  dbg_cmd_o, dbg_addr_o, dbg_data_o : debug command (8'h00 = NOP), address, write data
//  dbg_data_i, dbg_ready_i : debug read data and done flag
//  busy_o                  : high whenever not waiting for a new command byte
//  rx_drop_o               : one-cycle pulse when a received byte was discarded
module dbg_host_bridge
    import dbg_bridge_pkg::*;
#(
    parameter int unsigned DBG_TIMEOUT   = 1024,
    parameter int unsigned FRAME_TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [7:0]  dbg_cmd_o,
    output logic [31:0] dbg_addr_o,
    output logic [31:0] dbg_data_o,
    input  logic [31:0] dbg_data_i,
    input  logic        dbg_ready_i,
    output logic        busy_o,
    output logic        rx_drop_o
);

    // One counter serves both the frame-idle and debug timeouts.
    localparam int unsigned CNT_MAX = (DBG_TIMEOUT > FRAME_TIMEOUT) ? DBG_TIMEOUT : FRAME_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DBG_LIMIT   = CNT_W'(DBG_TIMEOUT);
    localparam logic [CNT_W-1:0] FRAME_LIMIT = CNT_W'(FRAME_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] FIELD_LAST  = IDX_W'(FIELD_BYTES - 1);
    localparam logic [IDX_W-1:0] RSP_LAST    = IDX_W'(RSP_BYTES - 1);

    state_e           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       cmd_sh;
    logic [31:0]      addr_sh;
    logic [31:0]      data_sh;
    logic [7:0]       status;
    logic [31:0]      rdata;

    logic [CNT_W-1:0] cnt_inc_c;
    logic [7:0]       rel_status_c;
    logic             rx_busy_c;

    assign cnt_inc_c    = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
    // A release timeout only replaces a successful status.
    assign rel_status_c = (status == STAT_OK) ? STAT_TO_REL : status;
    assign rx_busy_c    = (state == ISSUE) || (state == WAIT_RDY) ||
                          (state == RELEASE) || (state == TX_RESP);

    // Bridge FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state      <= RX_CMD;
            idx        <= '0;
            cnt        <= '0;
            cmd_sh     <= '0;
            addr_sh    <= '0;
            data_sh    <= '0;
            status     <= '0;
            rdata      <= '0;
            tx_data_o  <= '0;
            tx_valid_o <= 1'b0;
            dbg_cmd_o  <= '0;
            dbg_addr_o <= '0;
            dbg_data_o <= '0;
            busy_o     <= 1'b0;
            rx_drop_o  <= 1'b0;
        end else begin
            rx_drop_o <= rx_valid_i && rx_busy_c;

            case (state)
                RX_CMD: begin
                    if (rx_valid_i) begin
                        cmd_sh <= rx_data_i;
                        idx    <= '0;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= RX_ADDR;
                    end
                end

                RX_ADDR, RX_DATA: begin
                    if (cnt == FRAME_LIMIT) begin
                        // Idle too long: abandon the partial frame; a byte arriving now is lost.
                        rx_drop_o <= rx_valid_i;
                        idx       <= '0;
                        cnt       <= '0;
                        busy_o    <= 1'b0;
                        state     <= RX_CMD;
                    end else if (rx_valid_i) begin
                        cnt <= '0;
                        if (state == RX_ADDR) addr_sh <= {rx_data_i, addr_sh[31:8]};
                        else                  data_sh <= {rx_data_i, data_sh[31:8]};
                        if (idx == FIELD_LAST) begin
                            idx <= '0;
                            if (state == RX_ADDR) begin
                                state <= RX_DATA;
                            end else if (cmd_sh != 8'h00) begin
                                state <= ISSUE;
                            end else begin
                                status     <= STAT_INVAL;
                                rdata      <= '0;
                                tx_data_o  <= STAT_INVAL;
                                tx_valid_o <= 1'b1;
                                state      <= TX_RESP;
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt_inc_c;
                    end
                end

                ISSUE: begin
                    dbg_cmd_o  <= cmd_sh;
                    dbg_addr_o <= addr_sh;
                    dbg_data_o <= data_sh;
                    cnt        <= '0;
                    state      <= WAIT_RDY;
                end

                WAIT_RDY: begin
                    if (dbg_ready_i) begin
                        rdata     <= dbg_data_i;
                        status    <= STAT_OK;
                        dbg_cmd_o <= '0;
                        cnt       <= '0;
                        state     <= RELEASE;
                    end else if (cnt == DBG_LIMIT) begin
                        rdata     <= '0;
                        status    <= STAT_TO_RDY;
                        dbg_cmd_o <= '0;
                        cnt       <= '0;
                        state     <= RELEASE;
                    end else begin
                        cnt <= cnt_inc_c;
                    end
                end

                // Hold NOP until the port drops ready so the next command is a fresh request.
                RELEASE: begin
                    if (!dbg_ready_i) begin
                        idx        <= '0;
                        tx_data_o  <= status;
                        tx_valid_o <= 1'b1;
                        state      <= TX_RESP;
                    end else if (cnt == DBG_LIMIT) begin
                        status     <= rel_status_c;
                        idx        <= '0;
                        tx_data_o  <= rel_status_c;
                        tx_valid_o <= 1'b1;
                        state      <= TX_RESP;
                    end else begin
                        cnt <= cnt_inc_c;
                    end
                end

                TX_RESP: begin
                    if (tx_valid_o && tx_ready_i) begin
                        if (idx == RSP_LAST) begin
                            idx        <= '0;
                            tx_valid_o <= 1'b0;
                            busy_o     <= 1'b0;
                            state      <= RX_CMD;
                        end else begin
                            idx       <= idx + IDX_W'(1);
                            tx_data_o <= rsp_byte(status, rdata, idx + IDX_W'(1));
                        end
                    end
                end

                default: begin
                    busy_o <= 1'b0;
                    state  <= RX_CMD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_host_bridge.sv
// Directed self-checking bench for dbg_host_bridge.
// A background responder models the debug port: it raises ready a set number
// of cycles after a command appears and drops it once the command returns to NOP.
module tb_dbg_host_bridge;

    localparam int unsigned DBG_TO   = 1024;
    localparam int unsigned FRAME_TO = 300;

    logic        clk;
    logic        rst_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  dbg_cmd_o;
    logic [31:0] dbg_addr_o;
    logic [31:0] dbg_data_o;
    logic [31:0] dbg_data_i;
    logic        dbg_ready_i;
    logic        busy_o;
    logic        rx_drop_o;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          rdy_delay = 0;      // 0 = never assert ready
    bit          rdy_stuck = 0;      // ready ignores the NOP and stays high
    logic [31:0] rsp_data = 32'h0;

    dbg_host_bridge #(
        .DBG_TIMEOUT  (DBG_TO),
        .FRAME_TIMEOUT(FRAME_TO)
    ) dut (
        .clk        (clk),
        .rst_i      (rst_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .dbg_cmd_o  (dbg_cmd_o),
        .dbg_addr_o (dbg_addr_o),
        .dbg_data_o (dbg_data_o),
        .dbg_data_i (dbg_data_i),
        .dbg_ready_i(dbg_ready_i),
        .busy_o     (busy_o),
        .rx_drop_o  (rx_drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Debug port model.
    initial begin
        int cyc;
        cyc = 0;
        dbg_ready_i = 1'b0;
        dbg_data_i  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                dbg_ready_i = 1'b0;
                cyc = 0;
            end else if (dbg_cmd_o == 8'h00) begin
                if (!rdy_stuck) dbg_ready_i = 1'b0;
                cyc = 0;
            end else begin
                cyc++;
                if (rdy_delay > 0 && cyc >= rdy_delay) begin
                    dbg_ready_i = 1'b1;
                    dbg_data_i  = rsp_data;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // All tasks are entered and left just after a falling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(negedge clk);
        rx_valid_i = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
        send_byte(cmd);
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
    endtask

    // Collects one response (byte 0 in [7:0]), holding ready low for 'stall' cycles per byte.
    task automatic recv_rsp(input int stall, output logic [39:0] rsp, output int unstable, output bit tmo);
        logic [7:0] first;
        int n;
        rsp = '0;
        unstable = 0;
        tmo = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!tx_valid_o && n < 3000) begin
                @(negedge clk);
                n++;
            end
            if (!tx_valid_o) begin
                tmo = 1'b1;
                return;
            end
            first = tx_data_o;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                if (!tx_valid_o || tx_data_o !== first) unstable++;
            end
            tx_ready_i = 1'b1;
            @(negedge clk);
            tx_ready_i = 1'b0;
            rsp[8*i +: 8] = first;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00; tx_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        vec_cnt++; if (dbg_cmd_o !== 8'h00) begin err_cnt++; $display("FAIL reset_cmd: got %h want 00", dbg_cmd_o); end
        vec_cnt++; if ({tx_valid_o, busy_o, rx_drop_o} !== 3'b000) begin err_cnt++; $display("FAIL reset_flags: got %b want 000", {tx_valid_o, busy_o, rx_drop_o}); end
        vec_cnt++; if ({dbg_addr_o, dbg_data_o, tx_data_o} !== 72'h0) begin err_cnt++; $display("FAIL reset_data: got %h want 0", {dbg_addr_o, dbg_data_o, tx_data_o}); end
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [39:0] rsp; int unst; bit tmo;
        rdy_delay = 3; rsp_data = 32'hCAFEF00D;
        send_frame(8'h02, 32'h00000010, 32'hDEADBEEF);
        vec_cnt++; if ({busy_o, dbg_cmd_o} !== {1'b1, 8'h00}) begin err_cnt++; $display("FAIL basic_issue: got busy %b cmd %h want 1 00", busy_o, dbg_cmd_o); end
        @(negedge clk);
        vec_cnt++; if (dbg_cmd_o !== 8'h02) begin err_cnt++; $display("FAIL basic_cmd: got %h want 02", dbg_cmd_o); end
        vec_cnt++; if (dbg_addr_o !== 32'h00000010) begin err_cnt++; $display("FAIL basic_addr: got %h want 00000010", dbg_addr_o); end
        vec_cnt++; if (dbg_data_o !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL basic_data: got %h want deadbeef", dbg_data_o); end
        recv_rsp(0, rsp, unst, tmo);
        vec_cnt++; if (tmo !== 1'b0) begin err_cnt++; $display("FAIL basic_tmo: got %b want 0", tmo); end
        vec_cnt++; if (rsp !== 40'hCAFEF00D00) begin err_cnt++; $display("FAIL basic_rsp: got %h want cafef00d00", rsp); end
        @(negedge clk);
        vec_cnt++; if ({busy_o, tx_valid_o} !== 2'b00) begin err_cnt++; $display("FAIL basic_idle: got %b want 00", {busy_o, tx_valid_o}); end
    endtask

    task automatic test_rdy_timeout();
        logic [39:0] rsp; int unst; bit tmo; int n;
        rdy_delay = 0;
        send_frame(8'h02, 32'h00000010, 32'hDEADBEEF);
        @(negedge clk);
        n = 0;
        while (dbg_cmd_o != 8'h00 && n < 3000) begin
            n++;
            @(negedge clk);
        end
        vec_cnt++; if (n < 1024 || n > 1026) begin err_cnt++; $display("FAIL rto_cmd_cycles: got %0d want 1024..1026", n); end
        recv_rsp(0, rsp, unst, tmo);
        vec_cnt++; if (tmo !== 1'b0) begin err_cnt++; $display("FAIL rto_tmo: got %b want 0", tmo); end
        vec_cnt++; if (rsp !== 40'h00000000EE) begin err_cnt++; $display("FAIL rto_rsp: got %h want 00000000ee", rsp); end
    endtask

    task automatic test_invalid();
        logic [39:0] rsp; int unst; bit tmo;
        rdy_delay = 3;
        send_frame(8'h00, 32'h11223344, 32'h55667788);
        vec_cnt++; if ({tx_valid_o, dbg_cmd_o} !== {1'b1, 8'h00}) begin err_cnt++; $display("FAIL inval_state: got valid %b cmd %h want 1 00", tx_valid_o, dbg_cmd_o); end
        recv_rsp(0, rsp, unst, tmo);
        vec_cnt++; if (rsp !== 40'h0000000001) begin err_cnt++; $display("FAIL inval_rsp: got %h want 0000000001", rsp); end
        vec_cnt++; if (dbg_cmd_o !== 8'h00) begin err_cnt++; $display("FAIL inval_cmd: got %h want 00", dbg_cmd_o); end
    endtask

    task automatic test_frame_timeout();
        logic [39:0] rsp; int unst; bit tmo; bit extra;
        send_byte(8'h02); send_byte(8'h10); send_byte(8'h00);
        repeat (FRAME_TO) @(negedge clk);
        vec_cnt++; if (busy_o !== 1'b1) begin err_cnt++; $display("FAIL fto_before: busy got %b want 1", busy_o); end
        @(negedge clk);
        vec_cnt++; if ({busy_o, rx_drop_o} !== 2'b00) begin err_cnt++; $display("FAIL fto_expire: got %b want 00", {busy_o, rx_drop_o}); end
        rdy_delay = 3; rsp_data = 32'h0BADF00D;
        send_frame(8'h03, 32'h00000020, 32'h00000001);
        @(negedge clk);
        vec_cnt++; if ({dbg_cmd_o, dbg_addr_o} !== {8'h03, 32'h00000020}) begin err_cnt++; $display("FAIL fto_newcmd: got %h want 0300000020", {dbg_cmd_o, dbg_addr_o}); end
        recv_rsp(0, rsp, unst, tmo);
        vec_cnt++; if (rsp !== 40'h0BADF00D00) begin err_cnt++; $display("FAIL fto_rsp: got %h want 0badf00d00", rsp); end
        extra = 1'b0;
        repeat (20) begin @(negedge clk); if (tx_valid_o) extra = 1'b1; end
        vec_cnt++; if (extra !== 1'b0) begin err_cnt++; $display("FAIL fto_extra_rsp: got %b want 0", extra); end
    endtask

    task automatic test_timeout_collision();
        // A byte one cycle before expiry is still accepted.
        send_byte(8'h01);
        repeat (FRAME_TO - 1) @(negedge clk);
        send_byte(8'hAA);
        vec_cnt++; if ({busy_o, rx_drop_o} !== 2'b10) begin err_cnt++; $display("FAIL coll_early: got %b want 10", {busy_o, rx_drop_o}); end
        repeat (FRAME_TO + 2) @(negedge clk);
        // A byte on the expiry cycle loses to the timeout.
        send_byte(8'h01);
        repeat (FRAME_TO) @(negedge clk);
        send_byte(8'hAA);
        vec_cnt++; if ({busy_o, rx_drop_o} !== 2'b01) begin err_cnt++; $display("FAIL coll_expire: got %b want 01", {busy_o, rx_drop_o}); end
        @(negedge clk);
        vec_cnt++; if (rx_drop_o !== 1'b0) begin err_cnt++; $display("FAIL coll_pulse: got %b want 0", rx_drop_o); end
    endtask

    task automatic test_rx_drop();
        logic [39:0] rsp; int unst; bit tmo;
        rdy_delay = 20; rsp_data = 32'h12345678;
        send_frame(8'h04, 32'h00000100, 32'hA5A5A5A5);
        repeat (5) @(negedge clk);
        vec_cnt++; if (rx_drop_o !== 1'b0) begin err_cnt++; $display("FAIL drop_before: got %b want 0", rx_drop_o); end
        send_byte(8'h55);
        vec_cnt++; if (rx_drop_o !== 1'b1) begin err_cnt++; $display("FAIL drop_pulse: got %b want 1", rx_drop_o); end
        @(negedge clk);
        vec_cnt++; if ({rx_drop_o, dbg_cmd_o} !== {1'b0, 8'h04}) begin err_cnt++; $display("FAIL drop_after: got %h want 004", {rx_drop_o, dbg_cmd_o}); end
        recv_rsp(0, rsp, unst, tmo);
        vec_cnt++; if (rsp !== 40'h1234567800) begin err_cnt++; $display("FAIL drop_rsp: got %h want 1234567800", rsp); end
    endtask

    task automatic test_tx_stall();
        logic [39:0] rsp; int unst; bit tmo;
        rdy_delay = 2; rsp_data = 32'h89ABCDEF;
        send_frame(8'h05, 32'h00000004, 32'h00000000);
        recv_rsp(10, rsp, unst, tmo);
        vec_cnt++; if (unst !== 0) begin err_cnt++; $display("FAIL stall_stable: got %0d changes want 0", unst); end
        vec_cnt++; if (rsp !== 40'h89ABCDEF00) begin err_cnt++; $display("FAIL stall_rsp: got %h want 89abcdef00", rsp); end
    endtask

    task automatic test_release_timeout();
        logic [39:0] rsp; int unst; bit tmo;
        rdy_delay = 2; rdy_stuck = 1'b1; rsp_data = 32'h13579BDF;
        send_frame(8'h06, 32'h00000008, 32'h00000000);
        recv_rsp(0, rsp, unst, tmo);
        rdy_stuck = 1'b0;
        vec_cnt++; if (tmo !== 1'b0) begin err_cnt++; $display("FAIL rel_tmo: got %b want 0", tmo); end
        vec_cnt++; if (rsp !== 40'h13579BDFED) begin err_cnt++; $display("FAIL rel_rsp: got %h want 13579bdfed", rsp); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [39:0] rsp; int unst; bit tmo; bit seen;
        rdy_delay = 0;
        send_frame(8'h07, 32'h0000000C, 32'h00000000);
        repeat (10) @(negedge clk);
        vec_cnt++; if (dbg_cmd_o !== 8'h07) begin err_cnt++; $display("FAIL rstm_wait: got %h want 07", dbg_cmd_o); end
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        vec_cnt++; if ({dbg_cmd_o, busy_o, tx_valid_o} !== 10'h000) begin err_cnt++; $display("FAIL rstm_abort: got %h want 000", {dbg_cmd_o, busy_o, tx_valid_o}); end
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (tx_valid_o || dbg_cmd_o != 8'h00) seen = 1'b1; end
        vec_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL rstm_quiet: got %b want 0", seen); end
        rdy_delay = 1; rsp_data = 32'h00C0FFEE;
        send_frame(8'h08, 32'h00000000, 32'h00000000);
        recv_rsp(0, rsp, unst, tmo);
        vec_cnt++; if (rsp !== 40'h00C0FFEE00) begin err_cnt++; $display("FAIL rstm_recover: got %h want 00c0ffee00", rsp); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rdy_timeout();
        test_invalid();
        test_frame_timeout();
        test_timeout_collision();
        test_rx_drop();
        test_tx_stall();
        test_release_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
